// File: rtl/change_dispenser_if.sv
// Handshake bundle between the change dispenser, the credit FSM and the coin hopper.
// The master modport is the environment side; the slave modport is the dispenser.
interface change_dispenser_if #(
  parameter int CREDIT_W = 3
);
  logic [CREDIT_W-1:0] credit_in;
  logic                refund_req;
  logic                hopper_ack;
  logic                fault_clr;
  logic                coin_out;
  logic                clear_credit;
  logic [CREDIT_W-1:0] remaining;
  logic                busy;
  logic                done;
  logic                fault;

  modport master (
    output credit_in, refund_req, hopper_ack, fault_clr,
    input  coin_out, clear_credit, remaining, busy, done, fault
  );

  modport slave (
    input  credit_in, refund_req, hopper_ack, fault_clr,
    output coin_out, clear_credit, remaining, busy, done, fault
  );
endinterface

// File: rtl/change_dispenser.sv
// Refund engine: latches and clears the credit, then pays it out one hopper pulse per
// coin with ack timeout, bounded re-pulsing and a sticky fault until fault_clr.
module change_dispenser #(
  parameter int CREDIT_W       = 3,
  parameter int PULSE_CYCLES   = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RETRY      = 2
) (
  input  logic              clk,
  input  logic              reset,
  change_dispenser_if.slave bus
);

  localparam int PULSE_W = (PULSE_CYCLES > 1) ? $clog2(PULSE_CYCLES) : 1;
  localparam int TO_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam int RETRY_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

  localparam logic [PULSE_W-1:0] PULSE_LAST   = PULSE_W'(PULSE_CYCLES - 1);
  localparam logic [TO_W-1:0]    TIMEOUT_LAST = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX    = RETRY_W'(MAX_RETRY);

  typedef enum logic [2:0] {
    S_IDLE,
    S_PULSE,
    S_WAIT_ACK,
    S_DONE,
    S_FAULT
  } state_t;

  state_t              r_state;
  logic [CREDIT_W-1:0] r_remaining;
  logic [PULSE_W-1:0]  r_pulse_cnt;
  logic [TO_W-1:0]     r_timeout_cnt;
  logic [RETRY_W-1:0]  r_retry;
  logic                r_coin_out;
  logic                r_clear_credit;
  logic                r_busy;
  logic                r_done;
  logic                r_fault;

  // Saturating decrement: the owed count must never wrap.
  logic [CREDIT_W-1:0] w_remaining_dec;
  assign w_remaining_dec = (r_remaining != '0) ? r_remaining - 1'b1 : '0;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_remaining    <= '0;
      r_pulse_cnt    <= '0;
      r_timeout_cnt  <= '0;
      r_retry        <= '0;
      r_coin_out     <= 1'b0;
      r_clear_credit <= 1'b0;
      r_busy         <= 1'b0;
      r_done         <= 1'b0;
      r_fault        <= 1'b0;
    end else begin
      // NOTE: non-blocking defaults here make clear_credit and done one-cycle pulses;
      // any branch below that assigns them later wins for this edge only.
      r_clear_credit <= 1'b0;
      r_done         <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (bus.refund_req) begin
            r_busy <= 1'b1;
            if (bus.credit_in != '0) begin
              r_remaining    <= bus.credit_in;
              r_clear_credit <= 1'b1;
              r_retry        <= '0;
              r_pulse_cnt    <= '0;
              r_coin_out     <= 1'b1;
              r_state        <= S_PULSE;
            end else begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end

        S_PULSE: begin
          if (r_pulse_cnt == PULSE_LAST) begin
            r_coin_out    <= 1'b0;
            r_timeout_cnt <= '0;
            r_state       <= S_WAIT_ACK;
          end else begin
            r_pulse_cnt <= r_pulse_cnt + 1'b1;
          end
        end

        S_WAIT_ACK: begin
          // An ack on the last waiting cycle still counts; it outranks the timeout.
          if (bus.hopper_ack) begin
            r_remaining   <= w_remaining_dec;
            r_retry       <= '0;
            r_timeout_cnt <= '0;
            if (w_remaining_dec == '0) begin
              r_done  <= 1'b1;
              r_state <= S_DONE;
            end else begin
              r_pulse_cnt <= '0;
              r_coin_out  <= 1'b1;
              r_state     <= S_PULSE;
            end
          end else if (r_timeout_cnt == TIMEOUT_LAST) begin
            r_timeout_cnt <= '0;
            if (r_retry < RETRY_MAX) begin
              r_retry     <= r_retry + 1'b1;
              r_pulse_cnt <= '0;
              r_coin_out  <= 1'b1;
              r_state     <= S_PULSE;
            end else begin
              r_fault <= 1'b1;
              r_state <= S_FAULT;
            end
          end else begin
            r_timeout_cnt <= r_timeout_cnt + 1'b1;
          end
        end

        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end

        S_FAULT: begin
          if (bus.fault_clr) begin
            r_fault     <= 1'b0;
            r_busy      <= 1'b0;
            r_remaining <= '0;
            r_retry     <= '0;
            r_state     <= S_IDLE;
          end
        end

        default: begin
          r_coin_out <= 1'b0;
          r_busy     <= 1'b0;
          r_fault    <= 1'b0;
          r_state    <= S_IDLE;
        end
      endcase
    end
  end

  assign bus.coin_out     = r_coin_out;
  assign bus.clear_credit = r_clear_credit;
  assign bus.remaining    = r_remaining;
  assign bus.busy         = r_busy;
  assign bus.done         = r_done;
  assign bus.fault        = r_fault;

`ifndef SYNTHESIS
  a_busy_state:  assert property (@(posedge clk) disable iff (reset) r_busy == (r_state != S_IDLE));
  a_coin_state:  assert property (@(posedge clk) disable iff (reset) r_coin_out == (r_state == S_PULSE));
  a_fault_state: assert property (@(posedge clk) disable iff (reset) r_fault == (r_state == S_FAULT));
  a_done_state:  assert property (@(posedge clk) disable iff (reset) r_done == (r_state == S_DONE));
`endif

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: each task drives one scenario and compares the
// recorded coin/clear/done/remaining activity with hand-computed cycle numbers.
module tb_change_dispenser;

  localparam int CREDIT_W = 3;

  logic clk = 1'b0;
  logic reset;

  change_dispenser_if #(.CREDIT_W(CREDIT_W)) bus ();

  change_dispenser #(
    .CREDIT_W      (CREDIT_W),
    .PULSE_CYCLES  (4),
    .TIMEOUT_CYCLES(16),
    .MAX_RETRY     (2)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Activity recorded by observe(); cycle 1 is the cycle after the refund edge.
  int n_pulses, n_clear, clear_cyc, n_done, done_cyc, fault_cyc, first_coin_cyc, end_cyc;
  int pulse_w[8];
  int gap[8];
  logic [CREDIT_W-1:0] rem_log[$];
  bit timed_out;

  task automatic start_refund(input logic [CREDIT_W-1:0] c);
    @(negedge clk);
    bus.credit_in  = c;
    bus.refund_req = 1'b1;
  endtask

  // Plays the hopper for up to max_cyc cycles: acks on the ack_wait-th waiting cycle once
  // ack_min_pulse pulses were seen, or holds ack high throughout when ack_hold is set.
  task automatic observe(input int max_cyc, input int ack_wait, input int ack_min_pulse,
                         input bit ack_hold, input bit refund_noise);
    logic prev_coin;
    logic [CREDIT_W-1:0] prev_rem;
    int wait_cnt;
    bit waiting, stop, seen_busy;
    n_pulses = 0; n_clear = 0; clear_cyc = -1; n_done = 0; done_cyc = -1;
    fault_cyc = -1; first_coin_cyc = -1; end_cyc = -1;
    for (int i = 0; i < 8; i++) begin pulse_w[i] = 0; gap[i] = -1; end
    rem_log.delete();
    prev_rem = bus.remaining;
    prev_coin = 1'b0;
    wait_cnt = 0;
    seen_busy = 1'b0;
    timed_out = 1'b1;
    for (int cyc = 1; cyc <= max_cyc; cyc++) begin
      @(negedge clk);
      if (bus.coin_out && !prev_coin) begin
        if (n_pulses == 0) first_coin_cyc = cyc;
        else if (n_pulses <= 8) gap[n_pulses-1] = wait_cnt;
        n_pulses++;
        wait_cnt = 0;
      end
      if (bus.coin_out && n_pulses >= 1 && n_pulses <= 8) pulse_w[n_pulses-1]++;
      waiting = !bus.coin_out && bus.busy && !bus.done && !bus.fault;
      if (waiting) wait_cnt++;
      if (bus.clear_credit) begin n_clear++; clear_cyc = cyc; end
      if (bus.done) begin n_done++; done_cyc = cyc; end
      if (bus.remaining !== prev_rem) begin
        rem_log.push_back(bus.remaining);
        prev_rem = bus.remaining;
      end
      prev_coin = bus.coin_out;
      stop = 1'b0;
      if (bus.fault) begin fault_cyc = cyc; stop = 1'b1; end
      if (seen_busy && !bus.busy) begin end_cyc = cyc; stop = 1'b1; end
      if (bus.busy) seen_busy = 1'b1;
      bus.refund_req = !stop && refund_noise && bus.busy;
      if (refund_noise) bus.credit_in = 3'd7;
      bus.hopper_ack = !stop && (ack_hold ||
                       (ack_wait != 0 && waiting && wait_cnt == ack_wait && n_pulses >= ack_min_pulse));
      if (stop) begin timed_out = 1'b0; break; end
    end
    bus.refund_req = 1'b0;
    bus.hopper_ack = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if ({bus.coin_out, bus.clear_credit, bus.remaining, bus.busy, bus.done, bus.fault} !== '0) begin
      bad++;
      $display("FAIL reset.outputs got=%b want=0",
               {bus.coin_out, bus.clear_credit, bus.remaining, bus.busy, bus.done, bus.fault});
    end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset.idle_busy got=%b want=0", bus.busy); end
  endtask

  task automatic test_three_coins();
    logic [CREDIT_W-1:0] exp_rem[4] = '{3'd3, 3'd2, 3'd1, 3'd0};
    start_refund(3'd3);
    observe(100, 2, 1, 1'b0, 1'b0);
    total++;
    if (timed_out) begin bad++; $display("FAIL three.finished got=timeout want=done"); end
    total++;
    if (n_pulses !== 3) begin bad++; $display("FAIL three.pulses got=%0d want=3", n_pulses); end
    for (int i = 0; i < 3; i++) begin
      total++;
      if (pulse_w[i] !== 4) begin bad++; $display("FAIL three.width[%0d] got=%0d want=4", i, pulse_w[i]); end
    end
    total++;
    if (first_coin_cyc !== 1) begin bad++; $display("FAIL three.first_coin got=%0d want=1", first_coin_cyc); end
    total++;
    if (n_clear !== 1 || clear_cyc !== 1) begin
      bad++; $display("FAIL three.clear got=%0d@%0d want=1@1", n_clear, clear_cyc);
    end
    total++;
    if (rem_log.size() !== 4) begin
      bad++; $display("FAIL three.rem_steps got=%0d want=4", rem_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        total++;
        if (rem_log[i] !== exp_rem[i]) begin
          bad++; $display("FAIL three.rem[%0d] got=%0d want=%0d", i, rem_log[i], exp_rem[i]);
        end
      end
    end
    total++;
    if (n_done !== 1 || done_cyc !== 19) begin
      bad++; $display("FAIL three.done got=%0d@%0d want=1@19", n_done, done_cyc);
    end
    total++;
    if (end_cyc !== 20) begin bad++; $display("FAIL three.busy_low got=%0d want=20", end_cyc); end
  endtask

  task automatic test_zero_credit();
    start_refund(3'd0);
    observe(20, 0, 1, 1'b0, 1'b0);
    total++;
    if (done_cyc !== 1 || n_done !== 1) begin
      bad++; $display("FAIL zero.done got=%0d@%0d want=1@1", n_done, done_cyc);
    end
    total++;
    if (end_cyc !== 2) begin bad++; $display("FAIL zero.busy_low got=%0d want=2", end_cyc); end
    total++;
    if (n_pulses !== 0 || n_clear !== 0) begin
      bad++; $display("FAIL zero.no_coin got=pulses %0d clears %0d want=0 0", n_pulses, n_clear);
    end
  endtask

  task automatic test_fault();
    start_refund(3'd2);
    observe(200, 0, 1, 1'b0, 1'b0);
    total++;
    if (fault_cyc !== 61) begin bad++; $display("FAIL fault.cycle got=%0d want=61", fault_cyc); end
    total++;
    if (n_pulses !== 3) begin bad++; $display("FAIL fault.pulses got=%0d want=3", n_pulses); end
    for (int i = 0; i < 2; i++) begin
      total++;
      if (gap[i] !== 16) begin bad++; $display("FAIL fault.gap[%0d] got=%0d want=16", i, gap[i]); end
    end
    total++;
    if (bus.remaining !== 3'd2) begin bad++; $display("FAIL fault.remaining got=%0d want=2", bus.remaining); end
    for (int i = 0; i < 4; i++) begin
      bus.hopper_ack = 1'b1;
      bus.refund_req = 1'b1;
      bus.credit_in  = 3'd5;
      @(negedge clk);
      total++;
      if ({bus.fault, bus.busy, bus.coin_out, bus.done, bus.remaining} !== {4'b1100, 3'd2}) begin
        bad++; $display("FAIL fault.hold[%0d] got=%b want=%b", i,
                        {bus.fault, bus.busy, bus.coin_out, bus.done, bus.remaining}, {4'b1100, 3'd2});
      end
    end
    bus.hopper_ack = 1'b0;
    bus.refund_req = 1'b0;
    bus.fault_clr  = 1'b1;
    @(negedge clk);
    bus.fault_clr = 1'b0;
    total++;
    if ({bus.fault, bus.busy, bus.remaining} !== {2'b00, 3'd0}) begin
      bad++; $display("FAIL fault.clear got=%b want=00000", {bus.fault, bus.busy, bus.remaining});
    end
  endtask

  task automatic test_retry_then_ack();
    start_refund(3'd1);
    observe(100, 2, 2, 1'b0, 1'b0);
    total++;
    if (n_pulses !== 2) begin bad++; $display("FAIL retry.pulses got=%0d want=2", n_pulses); end
    total++;
    if (done_cyc !== 27 || end_cyc !== 28) begin
      bad++; $display("FAIL retry.done got=%0d/%0d want=27/28", done_cyc, end_cyc);
    end
    total++;
    if (fault_cyc !== -1) begin bad++; $display("FAIL retry.no_fault got=%0d want=-1", fault_cyc); end
    total++;
    if (rem_log.size() !== 2 || rem_log[0] !== 3'd1 || rem_log[rem_log.size()-1] !== 3'd0) begin
      bad++; $display("FAIL retry.rem got=%0d steps want=1,0", rem_log.size());
    end
  endtask

  task automatic test_refund_ignored();
    start_refund(3'd2);
    observe(100, 1, 1, 1'b0, 1'b1);
    total++;
    if (n_clear !== 1) begin bad++; $display("FAIL noise.clear got=%0d want=1", n_clear); end
    total++;
    if (n_pulses !== 2 || done_cyc !== 11 || end_cyc !== 12) begin
      bad++; $display("FAIL noise.flow got=%0d pulses done@%0d end@%0d want=2 11 12", n_pulses, done_cyc, end_cyc);
    end
    total++;
    if (rem_log.size() !== 3 || rem_log[0] !== 3'd2) begin
      bad++; $display("FAIL noise.rem got=%0d steps want=2,1,0", rem_log.size());
    end
    bus.credit_in = 3'd0;
    @(negedge clk);
    total++;
    if (bus.busy !== 1'b0) begin bad++; $display("FAIL noise.no_queue got=%b want=0", bus.busy); end
  endtask

  task automatic test_ack_held();
    start_refund(3'd3);
    observe(100, 0, 1, 1'b1, 1'b0);
    total++;
    if (n_pulses !== 3 || done_cyc !== 16 || end_cyc !== 17) begin
      bad++; $display("FAIL held.flow got=%0d pulses done@%0d end@%0d want=3 16 17", n_pulses, done_cyc, end_cyc);
    end
    total++;
    if (gap[0] !== 1 || gap[1] !== 1) begin
      bad++; $display("FAIL held.gaps got=%0d,%0d want=1,1", gap[0], gap[1]);
    end
    total++;
    if (rem_log.size() !== 4) begin bad++; $display("FAIL held.rem got=%0d steps want=4", rem_log.size()); end
  endtask

  task automatic test_reset_mid_refund();
    start_refund(3'd5);
    observe(11, 2, 1, 1'b0, 1'b0);
    total++;
    if ({bus.busy, bus.coin_out, bus.remaining} !== {2'b10, 3'd4}) begin
      bad++; $display("FAIL midreset.before got=%b want=10100", {bus.busy, bus.coin_out, bus.remaining});
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if ({bus.coin_out, bus.clear_credit, bus.remaining, bus.busy, bus.done, bus.fault} !== '0) begin
      bad++; $display("FAIL midreset.async got=%b want=0",
                      {bus.coin_out, bus.clear_credit, bus.remaining, bus.busy, bus.done, bus.fault});
    end
    @(negedge clk);
    reset = 1'b0;
    start_refund(3'd1);
    observe(50, 1, 1, 1'b0, 1'b0);
    total++;
    if (n_clear !== 1 || clear_cyc !== 1 || done_cyc !== 6 || end_cyc !== 7) begin
      bad++; $display("FAIL midreset.after got=clr %0d@%0d done@%0d end@%0d want=1@1 6 7",
                      n_clear, clear_cyc, done_cyc, end_cyc);
    end
  endtask

  initial begin
    reset          = 1'b1;
    bus.credit_in  = '0;
    bus.refund_req = 1'b0;
    bus.hopper_ack = 1'b0;
    bus.fault_clr  = 1'b0;
    test_reset();
    test_three_coins();
    test_zero_credit();
    test_fault();
    test_retry_then_ack();
    test_refund_ignored();
    test_ack_held();
    test_reset_mid_refund();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=still running want=finished");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Refund/change-return engine for the vending machine: the outgoing end of the coin path. It takes the accumulated credit from the credit FSM, zeroes that credit, and pays it back one coin per unit through a hopper using a pulse/acknowledge handshake with timeout, retry and fault reporting. It sits beside the credit and product FSMs on the prescaled internal clock.

## Interface

Parameters:
- `CREDIT_W`, 3: width of credit and remaining count.
- `PULSE_CYCLES`, 4: coin_out high time per coin, in clocks (≥1).
- `TIMEOUT_CYCLES`, 16: clocks to wait for hopper_ack after a pulse (≥1).
- `MAX_RETRY`, 2: re-pulses allowed per coin before fault.

Ports:
- `clk`  in  1  internal (prescaled) clock; all logic on rising edge.
- `reset`  in  1  asynchronous, active-high; forces the reset state immediately.
- `credit_in`  in  CREDIT_W  current credit from credit FSM.
- `refund_req`  in  1  refund request, sampled at the clock edge.
- `hopper_ack`  in  1  hopper coin-sensed, synchronous, sampled at the clock edge.
- `fault_clr`  in  1  clears FAULT.
- `coin_out`  out  1  eject pulse to hopper, registered.
- `clear_credit`  out  1  one-cycle pulse telling the credit FSM to zero credit.
- `remaining`  out  CREDIT_W  coins still owed.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle refund-complete pulse.
- `fault`  out  1  high while in FAULT.

## Operation

- States: IDLE, PULSE, WAIT_ACK, DONE, FAULT.
- Reset: state IDLE. All outputs 0: coin_out, clear_credit, remaining, busy, done, fault. Pulse, timeout and retry counters are 0.
- IDLE, refund_req=1, credit_in≠0:
  - latch remaining←credit_in.
  - clear_credit=1 for the next cycle only.
  - go to PULSE with retry=0.
- IDLE, refund_req=1, credit_in=0: go to DONE. No coin_out, no clear_credit.
- PULSE:
  - coin_out=1 for exactly PULSE_CYCLES cycles, then WAIT_ACK.
  - hopper_ack is ignored in PULSE.
- WAIT_ACK, coin_out=0:
  - hopper_ack=1: remaining←remaining−1 and retry←0. Go to DONE if the new remaining is 0, else PULSE.
  - No ack in TIMEOUT_CYCLES cycles: if retry<MAX_RETRY, retry+1 and back to PULSE for the same coin (remaining unchanged). Otherwise go to FAULT.
- DONE: done=1 for one cycle, then IDLE.
- FAULT:
  - fault=1, busy=1, remaining frozen.
  - hopper_ack and refund_req are ignored.
  - fault_clr=1 → IDLE with remaining←0.
- refund_req outside IDLE is ignored; there is no queuing.
- remaining never wraps; it decrements only while non-zero.
- Multiple ack cycles: each WAIT_ACK cycle with hopper_ack=1 counts once. The hopper must drop ack before the next WAIT_ACK; an ack still high then counts again, by design.
- Reset mid-refund: immediately IDLE, all outputs 0. The coins not yet paid are lost, because credit was already cleared.

## Timing

- refund_req sampled high at edge N (IDLE, credit≠0). From cycle N+1: state PULSE, coin_out=1, clear_credit=1, busy=1, remaining valid.
- clear_credit is deasserted from cycle N+2.
- coin_out is high for cycles N+1 … N+PULSE_CYCLES. WAIT_ACK starts at cycle N+PULSE_CYCLES+1.
- Ack sampled at edge W in WAIT_ACK. At W+1: remaining updated, and either coin_out=1 (next PULSE) or done=1 (DONE).
- Per-coin minimum period is PULSE_CYCLES+1 cycles.
- Timeout: the last waiting cycle is the TIMEOUT_CYCLES-th WAIT_ACK cycle. The next cycle is PULSE (coin_out=1) or FAULT (fault=1).
- DONE lasts 1 cycle. busy=0 from the following cycle.
- Zero-credit request at edge N: done=1 at N+1, busy=1 at N+1, IDLE at N+2.
- fault_clr sampled at edge F: IDLE at F+1, with fault=0, busy=0, remaining=0.
- Async reset clears outputs without waiting for a clock edge.

## Test plan

- Credit 3, refund, ack 2 cycles after each pulse ends:
  - 3 coin_out pulses, each 4 cycles wide.
  - remaining steps 3→2→1→0; clear_credit exactly once at N+1.
  - done once; busy low the cycle after done.
- Credit 0, refund: done at N+1, coin_out never high, clear_credit never high.
- Credit 2, hopper never acks:
  - 3 pulses for coin 1, each separated by 16 idle cycles.
  - Then fault=1, remaining=2 held. ack and refund_req are ignored in FAULT.
  - fault_clr → IDLE, remaining=0.
- Credit 1, first attempt times out, ack after the second pulse: exactly 2 pulses, remaining 1→0, done, fault never high.
- Robustness:
  - refund_req pulsed during PULSE/WAIT_ACK has no effect.
  - hopper_ack held high throughout PULSE is not counted until WAIT_ACK.
  - hopper_ack held high across successive WAIT_ACKs counts once per WAIT_ACK.
- Credit 5, reset asserted mid-WAIT_ACK of coin 2: all outputs 0 asynchronously, state IDLE. A new refund after reset behaves normally.
